hex_display_arbiter: RTL and testbench
======================================

// Module: hex_display_arbiter
// PURPOSE
//  Shares one 4-bit seven_segment_display decoder/HEX digit among N_REQ nibble sources.
//  Round-robin grant with a fixed dwell time per source, so each requester is shown
//  for DWELL cycles in turn. Sits between requesters (switch banks, counters, status)
//  and seven_segment_display; NIBBLE drives its SW input, BLANK forces the digit off.
// PARAMETERS
//  N_REQ  4           number of requesters (2..8)
//  DWELL  50_000_000  cycles each grant is held before rotation (>=1; 1 s at 50 MHz)
// PORTS
//  CLOCK_50  in   1          system clock, all state on rising edge
//  RESET_N   in   1          asynchronous active-low reset
//  REQ       in   N_REQ      REQ[i]=1: source i wants the display (level, sampled each edge)
//  DATA      in   4*N_REQ    DATA[4*i+3:4*i] = nibble of source i
//  HOLD      in   1          1: freeze dwell counter, no timed rotation
//  GNT       out  N_REQ      one-hot grant, all-zero when idle (registered)
//  NIBBLE    out  4          value of granted source, to decoder (registered)
//  BLANK     out  1          1: no source granted, display off (registered)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clock deassert by board logic): state IDLE, GNT=0,
//    NIBBLE=4'h0, BLANK=1, dwell cnt=0, last-grant pointer=N_REQ-1 (index 0 wins first).
//  - Counter width $clog2(DWELL) (min 1); counts 0..DWELL-1, never wraps past DWELL-1.
//  - Round-robin pick: first i with REQ[i]=1 scanning ptr+1, ptr+2, ... mod N_REQ.
//    "Others" pick excludes current grantee; ptr updates to winner on every new grant.
//  - FSM states: IDLE, SHOW.
//  - IDLE: BLANK=1, GNT=0, NIBBLE=0. On edge with |REQ: -> SHOW, GNT=winner,
//    NIBBLE=DATA[winner] sampled same edge, BLANK=0, cnt=0. Latency REQ->GNT = 1 edge.
//  - SHOW, each edge, priority order:
//    1. REQ[cur]=0: others pick; winner -> new GNT, cnt=0; none -> IDLE (blank same edge).
//    2. HOLD=1: keep grant, cnt unchanged.
//    3. cnt==DWELL-1: others pick; winner -> handover, cnt=0 (no blank gap);
//       none -> keep cur, cnt=0.
//    4. else cnt=cnt+1, keep grant.
//  - In SHOW, NIBBLE follows DATA of the grantee registered: DATA change -> NIBBLE 1 edge
//    later. On handover NIBBLE takes new source's DATA at the switching edge.
//  - GNT always one-hot or zero; BLANK==(GNT==0) at all times.
//  - DWELL=1: rotation check every SHOW cycle (rotate each edge while others request).
//  - Reset mid-SHOW: outputs return to reset values immediately, pointer reset.
//  - REQ asserting while another source shown: waits for dwell expiry or grantee drop;
//    worst-case wait (N_REQ-1)*DWELL cycles with HOLD=0.
// TESTING (N_REQ=4, DWELL=4)
//  1. Reset with REQ=4'b1111 -> GNT=0, BLANK=1, NIBBLE=0; release -> 1st edge GNT=0001.
//  2. REQ=1111, DATA=16'h4321, HOLD=0 -> GNT 0001,0010,0100,1000,0001 each held 4 edges,
//     NIBBLE 1,2,3,4,1, BLANK stays 0.
//  3. REQ=0100 only, 12 edges -> GNT=0100 throughout, NIBBLE=3, no blank, cnt wraps 0.
//  4. Grant on 0001, drop REQ[0] at cnt=1 with REQ=1010 -> next edge GNT=0010, cnt=0;
//     drop all REQ -> next edge GNT=0, BLANK=1, NIBBLE=0.
//  5. REQ=0011, HOLD=1 for 20 edges -> GNT stays 0001; HOLD=0 -> handover to 0010 after
//     remaining dwell edges.
//  6. Granted source changes DATA 3->9 mid-dwell -> NIBBLE=9 exactly 1 edge later;
//     assert RESET_N=0 mid-dwell -> GNT=0, BLANK=1 asynchronously.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin sharing of one hex digit among N_REQ nibble sources with a fixed dwell per grant
module hex_display_arbiter #(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [4*N_REQ-1:0] DATA,
    input  logic               HOLD,
    output logic [N_REQ-1:0]   GNT,
    output logic [3:0]         NIBBLE,
    output logic               BLANK
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int PW = $clog2(N_REQ);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] ptr, idx, win_all, win_oth, nxt_ptr;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          any_all, any_oth, nxt_show;

    // scan downwards so the candidate nearest after ptr is the last one written
    always_comb begin
        any_all = 1'b0;
        any_oth = 1'b0;
        win_all = ptr;
        win_oth = ptr;
        idx     = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (REQ[idx]) begin
                any_all = 1'b1;
                win_all = idx;
                if (k < N_REQ) begin
                    any_oth = 1'b1;
                    win_oth = idx;
                end
            end
        end
    end

    // while showing, ptr always names the current grantee
    always_comb begin
        nxt_show = state == SHOW;
        nxt_ptr  = ptr;
        nxt_cnt  = cnt;
        if (state == IDLE) begin
            nxt_show = any_all;
            nxt_ptr  = any_all ? win_all : ptr;
            nxt_cnt  = '0;
        end else if (!REQ[ptr]) begin
            nxt_show = any_oth;
            nxt_ptr  = any_oth ? win_oth : ptr;
            nxt_cnt  = '0;
        end else if (!HOLD) begin
            nxt_ptr = (cnt == CW'(DWELL - 1)) && any_oth ? win_oth : ptr;
            nxt_cnt = cnt == CW'(DWELL - 1) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            ptr    <= PW'(N_REQ - 1);
            cnt    <= '0;
            GNT    <= '0;
            NIBBLE <= 4'h0;
            BLANK  <= 1'b1;
        end else begin
            state  <= nxt_show ? SHOW : IDLE;
            ptr    <= nxt_ptr;
            cnt    <= nxt_cnt;
            GNT    <= nxt_show ? N_REQ'(1) << nxt_ptr : '0;
            NIBBLE <= nxt_show ? DATA[4*nxt_ptr +: 4] : 4'h0;
            BLANK  <= !nxt_show;
        end
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed stimulus with an index-level round-robin model checked every cycle
module tb_hex_display_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [4*N-1:0] data = '0;
    logic          hold = 1'b0;
    logic [N-1:0]  gnt;
    logic [3:0]    nibble;
    logic          blank;

    int n_chk = 0;
    int n_fail = 0;
    bit done = 0;

    int m_cur = -1;
    int m_ptr = N - 1;
    int m_cnt = 0;
    int m_w;
    logic [3:0] m_nib = 4'h0;

    hex_display_arbiter #(.N_REQ(N), .DWELL(DW)) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .REQ(req),
        .DATA(data),
        .HOLD(hold),
        .GNT(gnt),
        .NIBBLE(nibble),
        .BLANK(blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input int from, input int span, input logic [N-1:0] r);
        for (int k = 1; k <= span; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = -1;
            m_ptr = N - 1;
            m_cnt = 0;
        end else if (m_cur < 0) begin
            m_cur = rr(m_ptr, N, req);
            if (m_cur >= 0) m_ptr = m_cur;
            m_cnt = 0;
        end else if (!req[m_cur]) begin
            m_cur = rr(m_cur, N - 1, req);
            if (m_cur >= 0) m_ptr = m_cur;
            m_cnt = 0;
        end else if (!hold) begin
            if (m_cnt == DW - 1) begin
                m_w = rr(m_cur, N - 1, req);
                if (m_w >= 0) begin
                    m_cur = m_w;
                    m_ptr = m_w;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        m_nib = (m_cur < 0 || !rst_n) ? 4'h0 : data[4*m_cur +: 4];
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("model_gnt", 8'(gnt), m_cur < 0 ? 8'h0 : 8'(1 << m_cur));
            chk("model_nibble", 8'(nibble), 8'(m_nib));
            chk("blank_vs_gnt", 8'(blank), 8'(gnt == '0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all sources requesting
        req  = 4'b1111;
        data = 16'h4321;
        step(2);
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_blank", 8'(blank), 8'h1);
        chk("rst_nibble", 8'(nibble), 8'h0);
        rst_n = 1'b1;
        step(1);
        chk("first_gnt", 8'(gnt), 8'h1);
        chk("first_nibble", 8'(nibble), 8'h1);
        // full rotation, each grant held DW edges
        step(3);
        chk("dwell_hold", 8'(gnt), 8'h1);
        step(1);
        chk("rot_gnt1", 8'(gnt), 8'h2);
        chk("rot_nib1", 8'(nibble), 8'h2);
        step(4);
        chk("rot_gnt2", 8'(gnt), 8'h4);
        chk("rot_nib2", 8'(nibble), 8'h3);
        step(4);
        chk("rot_gnt3", 8'(gnt), 8'h8);
        chk("rot_nib3", 8'(nibble), 8'h4);
        step(4);
        chk("rot_wrap", 8'(gnt), 8'h1);
        chk("rot_blank", 8'(blank), 8'h0);
        // single requester keeps the digit across dwell expiries
        req = 4'b0100;
        step(1);
        chk("solo_gnt", 8'(gnt), 8'h4);
        step(12);
        chk("solo_keep", 8'(gnt), 8'h4);
        chk("solo_nib", 8'(nibble), 8'h3);
        chk("solo_blank", 8'(blank), 8'h0);
        // grantee drop mid-dwell, then all drop
        req = 4'b0001;
        step(2);
        chk("drop_pre", 8'(gnt), 8'h1);
        req = 4'b1010;
        step(1);
        chk("drop_gnt", 8'(gnt), 8'h2);
        chk("drop_nib", 8'(nibble), 8'h2);
        req = 4'b0000;
        step(1);
        chk("idle_gnt", 8'(gnt), 8'h0);
        chk("idle_blank", 8'(blank), 8'h1);
        chk("idle_nib", 8'(nibble), 8'h0);
        // HOLD freezes rotation
        req  = 4'b0011;
        hold = 1'b1;
        step(1);
        chk("hold_gnt", 8'(gnt), 8'h1);
        step(20);
        chk("hold_keep", 8'(gnt), 8'h1);
        hold = 1'b0;
        step(3);
        chk("unhold_keep", 8'(gnt), 8'h1);
        step(1);
        chk("unhold_rot", 8'(gnt), 8'h2);
        // data follows the grantee one edge later
        data = 16'h4331;
        step(1);
        chk("data_nib3", 8'(nibble), 8'h3);
        data = 16'h4391;
        #2;
        chk("data_lag", 8'(nibble), 8'h3);
        step(1);
        chk("data_nib9", 8'(nibble), 8'h9);
        // asynchronous reset mid-dwell
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 8'(gnt), 8'h0);
        chk("arst_blank", 8'(blank), 8'h1);
        chk("arst_nib", 8'(nibble), 8'h0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("arst_restart", 8'(gnt), 8'h1);
        chk("arst_restart_nib", 8'(nibble), 8'h1);
        step(6);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
